// File: rtl/instruction_memory_responder.sv
// rtl/instruction_memory_responder.sv - instruction-fetch memory responder with program-load port
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   memory_load_request level-held fetch request
//   memory_address      halfword address of the requested instruction
//   memory_output_valid one-cycle pulse when instruction_out carries the fetched word
//   instruction_out     last returned instruction (NOP_WORD after reset)
//   busy                a read is in flight
//   write_enable        program-load write strobe
//   write_address       program-load address
//   write_data          program-load data
//   write_ready         writes are accepted (idle only)

module instruction_memory_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16,
   parameter int READ_LATENCY = 2,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD = 16'hBF00
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memory_load_request,
   input  logic [ADDR_WIDTH-1:0] memory_address,
   output logic                  memory_output_valid,
   output logic [DATA_WIDTH-1:0] instruction_out,
   output logic                  busy,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  write_ready
);

   typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

   localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   state_t                state;
   state_t                state_next;
   logic [3:0]            count;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  accept;
   logic                  capture;
   logic                  write_accept;
   logic [ADDR_WIDTH-1:0] read_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next          = state;
      accept              = 1'b0;
      capture             = 1'b0;
      write_accept        = 1'b0;
      memory_output_valid = 1'b0;
      busy                = 1'b1;
      write_ready         = 1'b0;
      case (state)
         IDLE: begin
            busy        = 1'b0;
            write_ready = 1'b1;
            // Program-load write wins; a level-held request simply waits a cycle.
            if (write_enable) begin
               write_accept = 1'b1;
            end else if (memory_load_request) begin
               accept = 1'b1;
               if (READ_LATENCY == 1) begin
                  capture    = 1'b1;
                  state_next = RESPOND;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (!memory_load_request) begin
               state_next = IDLE;
            end else if (count == 4'd1) begin
               capture    = 1'b1;
               state_next = RESPOND;
            end
         end
         RESPOND: begin
            memory_output_valid = 1'b1;
            state_next          = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // With latency 1 the word is captured at acceptance, straight from the live address.
   assign read_addr = (state == IDLE) ? memory_address : addr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count           <= 4'd0;
         addr_q          <= '0;
         instruction_out <= NOP_WORD;
      end else begin
         if (accept) begin
            count  <= LAT_M1;
            addr_q <= memory_address;
         end else if (state == WAIT) begin
            count <= count - 4'd1;
         end
         if (capture) begin
            instruction_out <= mem[read_addr];
         end
      end
   end

   // Store is deliberately left out of reset so a loaded program survives it.
   always_ff @(posedge clk) begin
      if (write_accept && !reset) begin
         mem[write_address] <= write_data;
      end
   end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// tb/tb_instruction_memory_responder.sv - randomized bench for instruction_memory_responder at latencies 1, 2 and 3

module tb_instruction_memory_responder;

   localparam logic [15:0] NOP = 16'hBF00;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        memory_load_request = 1'b0;
   logic [11:0] memory_address = '0;
   logic        write_enable = 1'b0;
   logic [11:0] write_address = '0;
   logic [15:0] write_data = '0;

   logic        v   [3];
   logic [15:0] io  [3];
   logic        bsy [3];
   logic        wr  [3];

   int errors = 0;
   int checks = 0;
   int edge_n = 0;

   // Transaction-level reference: per instance, pending read with its acceptance edge and data snapshot.
   logic [15:0] mem_m     [3][4096];
   bit          m_pending [3];
   bit          m_resp    [3];
   int          m_ea      [3];
   logic [15:0] m_d       [3];
   logic [15:0] m_out     [3];

   always #5 clk = ~clk;

   instruction_memory_responder #(.READ_LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .memory_load_request(memory_load_request),
      .memory_address(memory_address), .memory_output_valid(v[0]), .instruction_out(io[0]),
      .busy(bsy[0]), .write_enable(write_enable), .write_address(write_address),
      .write_data(write_data), .write_ready(wr[0]));

   instruction_memory_responder #(.READ_LATENCY(2)) u_l2 (
      .clk(clk), .reset(reset), .memory_load_request(memory_load_request),
      .memory_address(memory_address), .memory_output_valid(v[1]), .instruction_out(io[1]),
      .busy(bsy[1]), .write_enable(write_enable), .write_address(write_address),
      .write_data(write_data), .write_ready(wr[1]));

   instruction_memory_responder #(.READ_LATENCY(3)) u_l3 (
      .clk(clk), .reset(reset), .memory_load_request(memory_load_request),
      .memory_address(memory_address), .memory_output_valid(v[2]), .instruction_out(io[2]),
      .busy(bsy[2]), .write_enable(write_enable), .write_address(write_address),
      .write_data(write_data), .write_ready(wr[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_pending[i] = 1'b0;
         m_resp[i]    = 1'b0;
         m_out[i]     = NOP;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         int lat;
         lat = i + 1;
         if (reset) begin
            m_pending[i] = 1'b0;
            m_resp[i]    = 1'b0;
            m_out[i]     = NOP;
         end else if (m_resp[i]) begin
            m_resp[i] = 1'b0;
         end else if (m_pending[i]) begin
            if (!memory_load_request) begin
               m_pending[i] = 1'b0;
            end else if (edge_n == m_ea[i] + lat - 1) begin
               m_out[i]     = m_d[i];
               m_resp[i]    = 1'b1;
               m_pending[i] = 1'b0;
            end
         end else if (write_enable) begin
            mem_m[i][write_address] = write_data;
         end else if (memory_load_request) begin
            m_ea[i] = edge_n;
            m_d[i]  = mem_m[i][memory_address];
            if (lat == 1) begin
               m_out[i]  = m_d[i];
               m_resp[i] = 1'b1;
            end else begin
               m_pending[i] = 1'b1;
            end
         end
      end
      edge_n++;
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("valid_l%0d", i + 1), 32'(v[i]), 32'(m_resp[i]));
         check($sformatf("busy_l%0d", i + 1), 32'(bsy[i]), 32'(m_pending[i] | m_resp[i]));
         check($sformatf("wready_l%0d", i + 1), 32'(wr[i]), 32'(!(m_pending[i] | m_resp[i])));
         check($sformatf("iout_l%0d", i + 1), 32'(io[i]), 32'(m_out[i]));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic set_in(input bit req, input logic [11:0] addr, input bit we,
                         input logic [11:0] wa, input logic [15:0] wd);
      memory_load_request = req;
      memory_address      = addr;
      write_enable        = we;
      write_address       = wa;
      write_data          = wd;
   endtask

   task automatic idle(input int n);
      set_in(1'b0, 12'h000, 1'b0, 12'h000, 16'h0000);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic write_word(input logic [11:0] wa, input logic [15:0] wd);
      set_in(1'b0, 12'h000, 1'b1, wa, wd);
      cycle();
      write_enable = 1'b0;
   endtask

   function automatic logic [11:0] rnd_addr();
      logic [11:0] a;
      a = 12'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a + 12'd4032;
      return a;
   endfunction

   initial begin
      for (int i = 0; i < 3; i++)
         for (int a = 0; a < 4096; a++) mem_m[i][a] = 16'h0000;

      // Async reset observed without any clock edge.
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         check("rst_valid", 32'(v[i]), 32'd0);
         check("rst_busy", 32'(bsy[i]), 32'd0);
         check("rst_wready", 32'(wr[i]), 32'd1);
         check("rst_iout", 32'(io[i]), 32'(NOP));
      end
      cycle();
      cycle();
      reset = 1'b0;
      idle(2);

      // Preload the address windows used by the random phase (both ends of the range).
      for (int a = 0; a < 64; a++) write_word(12'(a), 16'($urandom));
      for (int a = 4032; a < 4096; a++) write_word(12'(a), 16'($urandom));
      idle(1);

      // Write then read back.
      write_word(12'h005, 16'h1234);
      set_in(1'b1, 12'h005, 1'b0, 12'h000, 16'h0000);
      cycle();
      check("t2_l1_valid", 32'(v[0]), 32'd1);
      check("t2_l2_not_yet", 32'(v[1]), 32'd0);
      cycle();
      check("t2_l2_valid", 32'(v[1]), 32'd1);
      check("t2_l2_data", 32'(io[1]), 32'h1234);
      cycle();
      check("t2_l2_pulse_end", 32'(v[1]), 32'd0);
      check("t2_l3_data", 32'(io[2]), 32'h1234);
      idle(3);
      check("t2_l2_held", 32'(io[1]), 32'h1234);

      // Write and request together: write first, read next.
      set_in(1'b1, 12'h010, 1'b1, 12'h010, 16'hA5A5);
      cycle();
      check("t3_not_busy", 32'(bsy[1]), 32'd0);
      write_enable = 1'b0;
      for (int k = 0; k < 3; k++) cycle();
      idle(3);
      for (int i = 0; i < 3; i++) check("t3_data", 32'(io[i]), 32'hA5A5);

      // Abort during WAIT for latency 3, then address change during WAIT.
      write_word(12'h020, 16'h2020);
      write_word(12'h021, 16'h2121);
      set_in(1'b1, 12'h020, 1'b0, 12'h000, 16'h0000);
      cycle();
      cycle();
      memory_load_request = 1'b0;
      cycle();
      check("t4_abort_idle", 32'(bsy[2]), 32'd0);
      check("t4_abort_iout", 32'(io[2]), 32'hA5A5);
      idle(2);
      set_in(1'b1, 12'h020, 1'b0, 12'h000, 16'h0000);
      cycle();
      memory_address = 12'h021;
      cycle();
      cycle();
      check("t4_latched_valid", 32'(v[2]), 32'd1);
      check("t4_latched_data", 32'(io[2]), 32'h2020);
      idle(3);

      // Back-to-back at latency 1.
      write_word(12'h000, 16'h0001);
      write_word(12'h001, 16'h0002);
      set_in(1'b1, 12'h000, 1'b0, 12'h000, 16'h0000);
      cycle();
      check("t5_first_valid", 32'(v[0]), 32'd1);
      check("t5_first_data", 32'(io[0]), 32'h0001);
      memory_address = 12'h001;
      cycle();
      check("t5_gap", 32'(v[0]), 32'd0);
      cycle();
      check("t5_second_valid", 32'(v[0]), 32'd1);
      check("t5_second_data", 32'(io[0]), 32'h0002);
      idle(4);

      // Reset while in WAIT; store survives.
      set_in(1'b1, 12'h005, 1'b0, 12'h000, 16'h0000);
      cycle();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      check("t6_rst_busy", 32'(bsy[2]), 32'd0);
      check("t6_rst_iout", 32'(io[2]), 32'(NOP));
      cycle();
      check("t6_no_valid", 32'(v[1]), 32'd0);
      reset = 1'b0;
      idle(3);
      set_in(1'b1, 12'h005, 1'b0, 12'h000, 16'h0000);
      for (int k = 0; k < 3; k++) cycle();
      memory_load_request = 1'b0;
      idle(2);
      for (int i = 0; i < 3; i++) check("t6_preserved", 32'(io[i]), 32'h1234);

      // Randomized traffic against the reference.
      for (int n = 0; n < 2000; n++) begin
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 299) == 0) reset = 1'b1;
         if (memory_load_request) begin
            if ($urandom_range(0, 7) == 0) memory_load_request = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            memory_load_request = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) memory_address = rnd_addr();
         write_enable = (!reset) && ($urandom_range(0, 4) == 0);
         write_address = rnd_addr();
         write_data = 16'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
